// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type and the RX-buffer status word.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

   typedef struct packed {
      logic full;
      logic empty;
      logic overrun;
      logic irq_hwm;
   } uart_rx_status_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage array: synchronous write port, asynchronous read port.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [UART_DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0]      raddr,
   output logic [UART_DATA_W-1:0] rdata
);

   uart_byte_t mem_q [DEPTH];

   // Storage is intentionally not reset; stale bytes are never exposed as valid.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer with sticky overrun flag.
// Define UART_RX_FIFO_HWM_EN to enable the registered high-water-mark output irq_hwm.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int HWM    = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rx_load,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [ADDR_W:0]        count,
   output logic                   full,
   output logic                   empty,
   output logic                   overrun,
   input  logic                   ovr_clr,
   output logic                   irq_hwm
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W != $clog2(DEPTH) ||
       HWM < 1 || HWM > DEPTH) begin : g_param_check
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and HWM in 1..DEPTH");
   end

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overrun_q, overrun_d;
   logic              push_s, pop_s, drop_s;
   logic              irq_hwm_s;
   uart_rx_status_t   status_s;

   always_comb begin
      pop_s     = (count_q != '0) && rd_ready;
      // A full buffer still accepts a byte when the same cycle frees a slot.
      push_s    = rx_load && ((count_q != DEPTH_C) || pop_s);
      drop_s    = rx_load && !push_s;
      wr_ptr_d  = push_s ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
      rd_ptr_d  = pop_s  ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop_s) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef UART_RX_FIFO_HWM_EN
   logic irq_hwm_q;

   // Compared against next-state count so the flag tracks occupancy without lag.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_hwm_q <= 1'b0;
      end else begin
         irq_hwm_q <= (count_d >= CNT_W'(HWM));
      end
   end

   assign irq_hwm_s = irq_hwm_q;
`else
   assign irq_hwm_s = 1'b0;
`endif

   uart_fifo_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (push_s && !reset),
      .waddr (wr_ptr_q),
      .wdata (rx_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign status_s = '{full:    (count_q == DEPTH_C),
                       empty:   (count_q == '0),
                       overrun: overrun_q,
                       irq_hwm: irq_hwm_s};

   assign count    = count_q;
   assign full     = status_s.full;
   assign empty    = status_s.empty;
   assign overrun  = status_s.overrun;
   assign irq_hwm  = status_s.irq_hwm;
   assign rd_valid = !status_s.empty;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences, randomized traffic.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int HWM   = 12;
`ifdef UART_RX_FIFO_HWM_EN
   localparam bit HWM_EN = 1'b1;
`else
   localparam bit HWM_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset, rx_load, rd_ready, ovr_clr;
   logic [7:0] rx_data, rd_data;
   logic       rd_valid, full, empty, overrun, irq_hwm;
   logic [4:0] count;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .HWM(HWM)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_load(rx_load),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .count(count), .full(full), .empty(empty), .overrun(overrun),
      .ovr_clr(ovr_clr), .irq_hwm(irq_hwm)
   );

   // Reference model: a byte queue plus a sticky drop flag.
   logic [7:0] mq[$];
   logic [7:0] popped[$];
   logic [7:0] pushed[$];
   logic       m_ovr;
   int         max_cnt;
   int         n_tests = 0;
   int         n_fail  = 0;

   typedef struct {
      logic       rst;
      logic       ld;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      int         exp_cnt;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ovr;
   } vec_t;

   vec_t tv[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("irq_hwm", 32'(irq_hwm), 32'(HWM_EN && (mq.size() >= HWM)));
      if (mq.size() != 0) begin
         chk("rd_data", 32'(rd_data), 32'(mq[0]));
      end
   endtask

   task automatic drive(input logic r, input logic ld, input logic [7:0] d,
                        input logic rdy, input logic clr);
      bit pop_m, push_m;
      reset = r; rx_load = ld; rx_data = d; rd_ready = rdy; ovr_clr = clr;
      pop_m  = (mq.size() > 0) && rdy;
      push_m = ld && ((mq.size() < DEPTH) || pop_m);
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         m_ovr = 1'b0;
      end else begin
         if (pop_m) popped.push_back(mq.pop_front());
         if (push_m) begin
            mq.push_back(d);
            pushed.push_back(d);
         end
         if (ld && !push_m) m_ovr = 1'b1;
         else if (clr) m_ovr = 1'b0;
      end
      if (mq.size() > max_cnt) max_cnt = mq.size();
      check_model();
   endtask

   initial begin
      logic [7:0] last_b;
      m_ovr = 1'b0;
      max_cnt = 0;

      tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tv[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tv[2]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0};
      tv[3]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 2, 1'b1, 8'h55, 1'b0};
      tv[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h55, 1'b0};
      tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'hA3, 1'b0};
      tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h00, 1'b0};
      tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tv[8]  = '{1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b0};
      tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
      tv[10] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
      tv[11] = '{1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 1, 1'b1, 8'h99, 1'b0};
      tv[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

      for (int i = 0; i < 13; i++) begin
         drive(tv[i].rst, tv[i].ld, tv[i].d, tv[i].rdy, tv[i].clr);
         chk("tv_count", 32'(count), 32'(tv[i].exp_cnt));
         chk("tv_valid", 32'(rd_valid), 32'(tv[i].exp_valid));
         chk("tv_overrun", 32'(overrun), 32'(tv[i].exp_ovr));
         if (tv[i].exp_valid) chk("tv_data", 32'(rd_data), 32'(tv[i].exp_data));
      end

      // Fill, then overflow with 0xEE.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovr_set", 32'(overrun), 32'd1);
      chk("ovr_count", 32'(count), 32'd16);
      // Set beats clear when both happen together.
      drive(1'b0, 1'b1, 8'hEF, 1'b0, 1'b1);
      chk("ovr_set_prio", 32'(overrun), 32'd1);
      popped.delete();
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) chk("drain_seq", 32'(popped[i]), 32'(8'h10 + i));
      chk("drain_empty", 32'(empty), 32'd1);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr_clr", 32'(overrun), 32'd0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("simul_count", 32'(count), 32'd16);
      chk("simul_ovr", 32'(overrun), 32'd0);
      popped.delete();
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      last_b = popped[15];
      chk("simul_last", 32'(last_b), 32'h77);

      // HWM threshold crossing.
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      chk("hwm_11", 32'(irq_hwm), 32'd0);
      drive(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0);
      chk("hwm_12", 32'(irq_hwm), 32'(HWM_EN));
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("hwm_pop", 32'(irq_hwm), 32'd0);

      // Reset mid-operation discards contents; push with reset ignored.
      drive(1'b1, 1'b1, 8'hAB, 1'b1, 1'b0);
      chk("rst_mid", 32'(count), 32'd0);

      // Wrap-around stream with random ready.
      pushed.delete();
      popped.delete();
      max_cnt = 0;
      for (int c = 0; c < 400 && pushed.size() < 40; c++)
         drive(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_pushed", 32'(pushed.size() >= 40), 32'd1);
      chk("wrap_len", 32'(popped.size()), 32'(pushed.size()));
      for (int i = 0; i < popped.size() && i < pushed.size(); i++)
         chk("wrap_stream", 32'(popped[i]), 32'(pushed[i]));
      chk("wrap_max", 32'(max_cnt <= DEPTH), 32'd1);

      // Free-running random traffic including clears and occasional reset.
      for (int c = 0; c < 600; c++)
         drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 8'($urandom),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo
